// File: rtl/reg_bus_router.sv
// Register-bus router: decodes each AXI-lite register request to one of NUM_SLOTS
// regions, strobes that slot, waits for its ack under a timeout and returns completion.
module reg_bus_router #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_SHIFT     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_reg_in_rdy,
    output logic                            o_reg_in_ack_stb,
    input  logic [ADDR_WIDTH-1:0]           i_reg_address,
    input  logic [DATA_WIDTH-1:0]           i_reg_in_data,
    input  logic                            i_reg_out_req,
    output logic                            o_reg_out_rdy_stb,
    output logic [DATA_WIDTH-1:0]           o_reg_out_data,
    output logic                            o_reg_invalid_addr,
    output logic [NUM_SLOTS-1:0]            o_slot_wr_stb,
    output logic [NUM_SLOTS-1:0]            o_slot_rd_stb,
    output logic [ADDR_WIDTH-1:0]           o_slot_addr,
    output logic [DATA_WIDTH-1:0]           o_slot_wdata,
    input  logic [NUM_SLOTS-1:0]            i_slot_ack,
    input  logic [NUM_SLOTS-1:0]            i_slot_err,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] i_slot_rdata,
    output logic [7:0]                      o_timeout_count
);

    localparam int SW        = $clog2(NUM_SLOTS);
    localparam int FIELD_TOP = SLOT_SHIFT + SW;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WRITE_ACCESS = 3'd1,
        READ_ACCESS  = 3'd2,
        RESPOND      = 3'd3,
        RELEASE      = 3'd4
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] low_mask(input int nbits);
        logic [ADDR_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            m[i] = (i < nbits) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] onehot(input logic [SW-1:0] idx);
        logic [NUM_SLOTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = low_mask(SLOT_SHIFT);
    localparam logic [ADDR_WIDTH-1:0] DECODE_MASK = low_mask(FIELD_TOP);
    localparam logic [15:0]           TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_SLOTS-1:0]  wr_stb_q, wr_stb_d;
    logic [NUM_SLOTS-1:0]  rd_stb_q, rd_stb_d;
    logic                  in_ack_q, in_ack_d;
    logic                  out_rdy_q, out_rdy_d;
    logic                  inval_q, inval_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]            tocnt_q, tocnt_d;

    logic [SW-1:0]         req_slot_s;
    logic                  req_oor_s;
    logic                  ack_k_s;
    logic                  err_k_s;
    logic [DATA_WIDTH-1:0] rdata_k_s;

    assign req_slot_s = i_reg_address[SLOT_SHIFT +: SW];
    assign req_oor_s  = |(i_reg_address & ~DECODE_MASK);
    assign ack_k_s    = i_slot_ack[slot_q];
    assign err_k_s    = i_slot_err[slot_q];
    assign rdata_k_s  = i_slot_rdata[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_stb_d  = '0;
        rd_stb_d  = '0;
        in_ack_d  = 1'b0;
        out_rdy_d = 1'b0;
        inval_d   = 1'b0;
        rdata_d   = '0;
        tocnt_d   = tocnt_q;

        case (state_q)
            IDLE: begin
                if (i_reg_in_rdy || i_reg_out_req) begin
                    is_wr_d = i_reg_in_rdy;
                    slot_d  = req_slot_s;
                    addr_d  = i_reg_address & OFFSET_MASK;
                    cnt_d   = 16'd0;
                    if (i_reg_in_rdy) begin
                        wdata_d = i_reg_in_data;
                    end else begin
                        wdata_d = wdata_q;
                    end
                    // Out-of-range requests complete immediately without touching any slot.
                    if (req_oor_s) begin
                        state_d   = RESPOND;
                        in_ack_d  = i_reg_in_rdy;
                        out_rdy_d = ~i_reg_in_rdy;
                        inval_d   = 1'b1;
                    end else if (i_reg_in_rdy) begin
                        state_d  = WRITE_ACCESS;
                        wr_stb_d = onehot(req_slot_s);
                    end else begin
                        state_d  = READ_ACCESS;
                        rd_stb_d = onehot(req_slot_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE_ACCESS, READ_ACCESS: begin
                // cnt_q == 0 marks the strobe cycle, where the slot ack is not yet trusted.
                if ((cnt_q != 16'd0) && ack_k_s) begin
                    state_d   = RESPOND;
                    in_ack_d  = is_wr_q;
                    out_rdy_d = ~is_wr_q;
                    inval_d   = err_k_s;
                    if (is_wr_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = rdata_k_s;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESPOND;
                    in_ack_d  = is_wr_q;
                    out_rdy_d = ~is_wr_q;
                    inval_d   = 1'b1;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end else begin
                        tocnt_d = tocnt_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESPOND: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!i_reg_in_rdy && !i_reg_out_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            slot_q    <= '0;
            cnt_q     <= 16'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            in_ack_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            inval_q   <= 1'b0;
            rdata_q   <= '0;
            tocnt_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            in_ack_q  <= in_ack_d;
            out_rdy_q <= out_rdy_d;
            inval_q   <= inval_d;
            rdata_q   <= rdata_d;
            tocnt_q   <= tocnt_d;
        end
    end

    assign o_reg_in_ack_stb   = in_ack_q;
    assign o_reg_out_rdy_stb  = out_rdy_q;
    assign o_reg_out_data     = rdata_q;
    assign o_reg_invalid_addr = inval_q;
    assign o_slot_wr_stb      = wr_stb_q;
    assign o_slot_rd_stb      = rd_stb_q;
    assign o_slot_addr        = addr_q;
    assign o_slot_wdata       = wdata_q;
    assign o_timeout_count    = tocnt_q;

endmodule

// File: tb/tb_reg_bus_router.sv
// Directed, table-driven bench for reg_bus_router with a scripted slot responder
// plus hand-written reset-abort sequence.
module tb_reg_bus_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_reg_in_rdy;
    logic         o_reg_in_ack_stb;
    logic [31:0]  i_reg_address;
    logic [31:0]  i_reg_in_data;
    logic         i_reg_out_req;
    logic         o_reg_out_rdy_stb;
    logic [31:0]  o_reg_out_data;
    logic         o_reg_invalid_addr;
    logic [3:0]   o_slot_wr_stb;
    logic [3:0]   o_slot_rd_stb;
    logic [31:0]  o_slot_addr;
    logic [31:0]  o_slot_wdata;
    logic [3:0]   i_slot_ack;
    logic [3:0]   i_slot_err;
    logic [127:0] i_slot_rdata;
    logic [7:0]   o_timeout_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    reg_bus_router #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLOTS(4),
        .SLOT_SHIFT(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_reg_in_rdy(i_reg_in_rdy), .o_reg_in_ack_stb(o_reg_in_ack_stb),
        .i_reg_address(i_reg_address), .i_reg_in_data(i_reg_in_data),
        .i_reg_out_req(i_reg_out_req), .o_reg_out_rdy_stb(o_reg_out_rdy_stb),
        .o_reg_out_data(o_reg_out_data), .o_reg_invalid_addr(o_reg_invalid_addr),
        .o_slot_wr_stb(o_slot_wr_stb), .o_slot_rd_stb(o_slot_rd_stb),
        .o_slot_addr(o_slot_addr), .o_slot_wdata(o_slot_wdata),
        .i_slot_ack(i_slot_ack), .i_slot_err(i_slot_err),
        .i_slot_rdata(i_slot_rdata), .o_timeout_count(o_timeout_count)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_slot;
        int          ack_dly;   // ack this many cycles after the strobe; 0 = never
        logic        early;     // also ack during the strobe cycle
        logic        err;
        logic [3:0]  spur;      // other slots acking while waiting
        logic [31:0] rdata;
        int          hold;      // cycles the request stays high after completion
        logic        late;      // all slots ack during the hold period
        logic [3:0]  exp_wr;
        logic [3:0]  exp_rd;
        int          exp_nstb;
        logic [31:0] exp_saddr;
        int          exp_lat;
        logic        exp_wcomp;
        logic        exp_inv;
        logic [31:0] exp_data;
        logic [7:0]  exp_tocnt;
    } vec_t;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, "in_ack",  {31'd0, o_reg_in_ack_stb},   32'd0);
        chk(tag, "out_rdy", {31'd0, o_reg_out_rdy_stb},  32'd0);
        chk(tag, "inv",     {31'd0, o_reg_invalid_addr}, 32'd0);
        chk(tag, "rdata",   o_reg_out_data,              32'd0);
        chk(tag, "stb",     {24'd0, o_slot_wr_stb, o_slot_rd_stb}, 32'd0);
        chk(tag, "saddr",   o_slot_addr,                 32'd0);
        chk(tag, "swdata",  o_slot_wdata,                32'd0);
        chk(tag, "tocnt",   {24'd0, o_timeout_count},    32'd0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int          s;
        int          cc;
        int          nstb;
        int          ncomp;
        logic [3:0]  wseen;
        logic [3:0]  rseen;
        logic [31:0] saddr;
        logic [31:0] swd;
        logic        wcomp;
        logic        inv;
        logic [31:0] data;
        logic        post_ok;
        s = -1; cc = -1; nstb = 0; ncomp = 0;
        wseen = 4'd0; rseen = 4'd0; saddr = 32'd0; swd = 32'd0;
        wcomp = 1'b0; inv = 1'b0; data = 32'd0; post_ok = 1'b0;

        i_reg_in_rdy  = v.wr;
        i_reg_out_req = v.rd;
        i_reg_address = v.addr;
        i_reg_in_data = v.wdata;
        i_slot_ack    = 4'd0;
        i_slot_err    = 4'd0;
        for (int k = 0; k < 4; k++) begin
            i_slot_rdata[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
        end
        i_slot_rdata[v.ack_slot*32 +: 32] = v.rdata;

        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if ((o_slot_wr_stb != 4'd0) || (o_slot_rd_stb != 4'd0)) begin
                nstb++;
                wseen |= o_slot_wr_stb;
                rseen |= o_slot_rd_stb;
                if (s < 0) begin
                    s = c; saddr = o_slot_addr; swd = o_slot_wdata;
                end
            end
            if (o_reg_in_ack_stb || o_reg_out_rdy_stb) begin
                ncomp++;
                if (cc < 0) begin
                    cc = c; wcomp = o_reg_in_ack_stb; inv = o_reg_invalid_addr; data = o_reg_out_data;
                end
            end
            if (cc >= 0 && c == cc + 1) begin
                post_ok = (o_reg_invalid_addr == 1'b0) && (o_reg_out_data == 32'd0);
            end
            i_slot_ack = 4'd0;
            i_slot_err = 4'd0;
            if (s >= 0 && cc < 0) begin
                if (c > s && c <= s + v.ack_dly) begin
                    i_slot_ack = v.spur;
                end
                if ((v.ack_dly > 0 && c == s + v.ack_dly) || (v.early && c == s)) begin
                    i_slot_ack[v.ack_slot] = 1'b1;
                    i_slot_err[v.ack_slot] = v.err;
                end
            end
            if (v.late && cc >= 0 && c > cc && c <= cc + v.hold) begin
                i_slot_ack = 4'hF;
            end
            if (cc >= 0 && c == cc + 1 + v.hold) begin
                i_reg_in_rdy  = 1'b0;
                i_reg_out_req = 1'b0;
            end
            if (cc >= 0 && c >= cc + v.hold + 4) begin
                break;
            end
        end
        i_reg_in_rdy  = 1'b0;
        i_reg_out_req = 1'b0;
        i_slot_ack    = 4'd0;
        i_slot_err    = 4'd0;

        chk(tag, "wr_stb",  {28'd0, wseen},  {28'd0, v.exp_wr});
        chk(tag, "rd_stb",  {28'd0, rseen},  {28'd0, v.exp_rd});
        chk(tag, "n_stb",   32'(nstb),       32'(v.exp_nstb));
        chk(tag, "latency", 32'(cc),         32'(v.exp_lat));
        chk(tag, "n_comp",  32'(ncomp),      32'd1);
        chk(tag, "kind",    {31'd0, wcomp},  {31'd0, v.exp_wcomp});
        chk(tag, "inv",     {31'd0, inv},    {31'd0, v.exp_inv});
        chk(tag, "rdata",   data,            v.exp_data);
        chk(tag, "cleared", {31'd0, post_ok}, 32'd1);
        chk(tag, "tocnt",   {24'd0, o_timeout_count}, {24'd0, v.exp_tocnt});
        if (v.exp_nstb > 0) begin
            chk(tag, "saddr", saddr, v.exp_saddr);
        end
        if (v.exp_nstb > 0 && v.wr) begin
            chk(tag, "swdata", swd, v.wdata);
        end
    endtask

    vec_t vecs[9];
    vec_t post_rst;

    initial begin
        //           wr rd addr           wdata         slot dly er err spur  rdata         hold late exp_wr exp_rd nstb saddr     lat wc inv data          tocnt
        vecs[0] = '{1'b1, 1'b0, 32'h0002_0010, 32'hA5A5_0001, 2, 1, 1'b0, 1'b0, 4'h0, 32'h0,         0, 1'b0, 4'h4, 4'h0, 1, 32'h10,   3, 1'b1, 1'b0, 32'h0,         8'd0};
        vecs[1] = '{1'b0, 1'b1, 32'h0001_0004, 32'h0,         1, 5, 1'b0, 1'b0, 4'h0, 32'h1234_5678, 4, 1'b0, 4'h0, 4'h2, 1, 32'h4,    7, 1'b0, 1'b0, 32'h1234_5678, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 32'h0004_0000, 32'h0,         0, 0, 1'b0, 1'b0, 4'h0, 32'h0,         0, 1'b0, 4'h0, 4'h0, 0, 32'h0,    1, 1'b0, 1'b1, 32'h0,         8'd0};
        vecs[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0000_BEEF, 1, 0, 1'b0, 1'b0, 4'h0, 32'h0,         3, 1'b1, 4'h2, 4'h0, 1, 32'h0,    9, 1'b1, 1'b1, 32'h0,         8'd1};
        vecs[4] = '{1'b1, 1'b0, 32'h0003_0020, 32'h5A5A_0003, 3, 3, 1'b0, 1'b1, 4'h1, 32'h0,         0, 1'b0, 4'h8, 4'h0, 1, 32'h20,   5, 1'b1, 1'b1, 32'h0,         8'd1};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055, 0, 1, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 0, 1'b0, 4'h1, 4'h0, 1, 32'h8,    3, 1'b1, 1'b0, 32'h0,         8'd1};
        vecs[6] = '{1'b0, 1'b1, 32'h0003_FFFC, 32'h0,         3, 1, 1'b0, 1'b0, 4'h0, 32'hCAFE_F00D, 0, 1'b0, 4'h0, 4'h8, 1, 32'hFFFC, 3, 1'b0, 1'b0, 32'hCAFE_F00D, 8'd1};
        vecs[7] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0,         1, 1'b0, 4'h0, 4'h0, 0, 32'h0,    1, 1'b1, 1'b1, 32'h0,         8'd1};
        vecs[8] = '{1'b0, 1'b1, 32'h0002_0040, 32'h0,         2, 2, 1'b1, 1'b0, 4'h0, 32'h0BAD_CAFE, 0, 1'b0, 4'h0, 4'h4, 1, 32'h40,   4, 1'b0, 1'b0, 32'h0BAD_CAFE, 8'd1};
        post_rst = '{1'b0, 1'b1, 32'h0002_0100, 32'h0,        2, 1, 1'b0, 1'b0, 4'h0, 32'h7777_0002, 0, 1'b0, 4'h0, 4'h4, 1, 32'h100,  3, 1'b0, 1'b0, 32'h7777_0002, 8'd0};

        rst           = 1'b0;
        i_reg_in_rdy  = 1'b0;
        i_reg_out_req = 1'b0;
        i_reg_address = 32'd0;
        i_reg_in_data = 32'd0;
        i_slot_ack    = 4'd0;
        i_slot_err    = 4'd0;
        i_slot_rdata  = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort a read in flight with reset; the still-held request must be serviced once.
        i_reg_out_req = 1'b1;
        i_reg_address = 32'h0002_0100;
        @(posedge clk);
        #1;
        chk("abort", "rd_stb", {28'd0, o_slot_rd_stb}, 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_idle_outputs("abort_now");
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("abort_held");
        rst = 1'b1;
        run_txn(post_rst, "reissue");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_bus_router.md
Name: reg_bus_router

Overview:
- Sequences the simple register user interface of the AXI-lite slave and shares it among NUM_SLOTS peripheral register regions.
- Decodes each request address into a slot and issues a single-cycle access strobe to that slot.
- Waits for the slot's acknowledge, guards the access with a timeout, and returns the completion strobe, read data and invalid-address flag on the same cycle.
- Sits directly between the AXI-lite slave and the peripheral register files.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_SLOTS, 4, number of downstream regions; power of two, 2..16.
- SLOT_SHIFT, 16, LSB position of the slot-select field; the field is SLOT_SHIFT +: log2(NUM_SLOTS).
- TIMEOUT_CYCLES, 255, cycles to wait for a slot ack before failing; range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_reg_in_rdy  in  1  write request from slave; held high until ack.
- o_reg_in_ack_stb  out  1  write completion, one-cycle pulse.
- i_reg_address  in  ADDR_WIDTH  request address.
- i_reg_in_data  in  DATA_WIDTH  write data.
- i_reg_out_req  in  1  read request; held high until the slave returns to idle.
- o_reg_out_rdy_stb  out  1  read completion, one-cycle pulse.
- o_reg_out_data  out  DATA_WIDTH  read data; valid while o_reg_out_rdy_stb is high.
- o_reg_invalid_addr  out  1  error flag; valid with either completion strobe.
- o_slot_wr_stb  out  NUM_SLOTS  one-hot write strobe, one-cycle pulse.
- o_slot_rd_stb  out  NUM_SLOTS  one-hot read strobe, one-cycle pulse.
- o_slot_addr  out  ADDR_WIDTH  address with the slot field and all bits above it zeroed.
- o_slot_wdata  out  DATA_WIDTH  write data to slot.
- i_slot_ack  in  NUM_SLOTS  per-slot access complete.
- i_slot_err  in  NUM_SLOTS  per-slot error; sampled together with ack.
- i_slot_rdata  in  NUM_SLOTS*DATA_WIDTH  per-slot read data; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_timeout_count  out  8  saturating count of timed-out accesses.

Behaviour:
- Reset (rst low, asynchronous): every output is 0, state goes to IDLE, timeout counter clears, o_timeout_count clears. Reset during an access abandons it with no completion strobe. A request still held after reset release is serviced normally.
- Address decode: the access is out of range if any address bit above the slot field is 1.
- States and transitions:
  - IDLE, i_reg_in_rdy=1: write has priority over a simultaneous i_reg_out_req. Latch address and data; pulse o_slot_wr_stb[k] on the next cycle; go to WRITE_ACCESS.
  - IDLE, i_reg_out_req=1 (no write): pulse o_slot_rd_stb[k] on the next cycle; go to READ_ACCESS.
  - IDLE, out-of-range address: no slot strobe. Go directly to RESPOND with invalid=1 and read data 0.
  - WRITE_ACCESS / READ_ACCESS: i_slot_ack[k] is ignored in the strobe cycle and sampled from the following cycle on; acks from any other slot are ignored. When ack[k] is sampled, capture err[k] (and rdata[k] for reads) and go to RESPOND.
  - Timeout: the counter increments each cycle in an ACCESS state. On reaching TIMEOUT_CYCLES with no ack, go to RESPOND with invalid=1 and data 0, and increment o_timeout_count (saturates at 255).
  - RESPOND: one cycle. Pulse o_reg_in_ack_stb (write) or o_reg_out_rdy_stb (read), with o_reg_invalid_addr and o_reg_out_data driven in the same cycle. Go to RELEASE.
  - RELEASE: hold until i_reg_in_rdy=0 and i_reg_out_req=0, then go to IDLE. This prevents a held request from being re-issued.
- Completion timing: for a 1-cycle slot (ack the cycle after the strobe), the completion strobe occurs 3 cycles after the request is first seen in IDLE.
- Output hold rules: o_reg_invalid_addr and o_reg_out_data return to 0 after RESPOND. o_slot_addr and o_slot_wdata hold their values until the next access. Late acks arriving in RELEASE or IDLE are ignored.

Test Plan:
- Write to addr 0x0002_0010 with data 0xA5A5_0001, slot 2 acks 1 cycle after the strobe → o_slot_wr_stb=4'b0100 for exactly 1 cycle, o_slot_addr=0x10, o_slot_wdata=0xA5A5_0001, o_reg_in_ack_stb pulses 3 cycles after request with invalid=0.
- Read addr 0x0001_0004, slot 1 returns rdata 0x1234_5678 with ack after 5 cycles → o_reg_out_rdy_stb pulses with o_reg_out_data=0x1234_5678 and invalid=0. i_reg_out_req held 4 more cycles → no second o_slot_rd_stb.
- Read addr 0x0004_0000 (out of range) → no slot strobe, o_reg_out_rdy_stb with invalid=1 and data 0.
- Write with TIMEOUT_CYCLES=8 to a slot that never acks → completion after 8 access cycles with invalid=1, o_timeout_count=1. Acks asserted in RELEASE are ignored.
- Slot 3 acks with err=1 while slot 0 asserts a spurious ack → invalid=1, slot 0 ack has no effect. Simultaneous i_reg_in_rdy and i_reg_out_req → write serviced.
- Assert rst low during READ_ACCESS → all outputs 0 immediately. After release with i_reg_out_req still high → read re-issued and completes once.
